clk_ctl: RTL and testbench

- Programmable CPU clock controller.
- Generates the registered phi2 clock and its edge strobes from the master clock using a runtime-loadable half-period.
- Sequences run, halt and single-step so phi2 only ever stops low and no phase is ever shortened.
- Sits between the master clock input and the CPU/bus logic; the debug/monitor interface drives its control and config ports.

---
 rtl/clk_ctl_pkg.sv | 17 +
 rtl/clk_ctl_phase_counter.sv | 33 +++
 rtl/clk_ctl.sv | 177 +++++++++++++++++
 tb/tb_clk_ctl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_ctl_pkg.sv
// clk_ctl_pkg: shared state encoding and half-period constants for the
// programmable CPU clock controller (clk_ctl) and its phase counter.
package clk_ctl_pkg;

   typedef enum logic [1:0] {
      ST_HALT = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2
   } state_t;

   // Half-period (in clk_in cycles) loaded by reset: 12-cycle period, 1 MHz from 12 MHz.
   localparam int unsigned DEFAULT_HALF = 6;

   // Smallest legal half-period; a config value of 0 is raised to this.
   localparam int unsigned MIN_HALF = 1;

endpackage

// File: rtl/clk_ctl_phase_counter.sv
// phase_counter: counts clk_in cycles within one phi2 phase and flags the
// terminal count (count == half-1). Synchronous clear has priority over enable.
module phase_counter
   import clk_ctl_pkg::*;
#(
   parameter int DIV_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [DIV_W-1:0] half,
   output logic [DIV_W-1:0] count,
   output logic             tc
);

   // Phase cycle counter: cleared at phase end or while halted, else advances when enabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= {DIV_W{1'b0}};
      end else if (clr) begin
         count <= {DIV_W{1'b0}};
      end else if (en) begin
         count <= count + {{(DIV_W-1){1'b0}}, 1'b1};
      end else begin
         count <= count;
      end
   end

   // half is never below 1, so half-1 cannot wrap.
   assign tc = (count == (half - {{(DIV_W-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/clk_ctl.sv
// clk_ctl: programmable CPU clock controller. Produces a registered phi2 with
// one-cycle rise/fall strobes from clk_in, sequencing run / halt / single-step
// so phi2 only stops low and no phase is ever shortened.
// Build option: define CLK_CTL_STEP_EN to include the single-step (STEP) state;
// without it step_req is ignored and step_done stays 0.
module clk_ctl
#(
   parameter int DIV_W    = 4,
   parameter int DEF_HALF = clk_ctl_pkg::DEFAULT_HALF
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             run_req,
   input  logic             step_req,
   input  logic             cfg_valid,
   input  logic [DIV_W-1:0] cfg_half,
   output logic             cfg_ready,
   output logic             phi2,
   output logic             phi2_rise,
   output logic             phi2_fall,
   output logic             halted,
   output logic             step_done
);
   import clk_ctl_pkg::*;

   state_t           state;
   state_t           state_nx;
   logic [DIV_W-1:0] half_reg;
   logic [DIV_W-1:0] half_nx;
   logic [DIV_W-1:0] count;
   logic [DIV_W-1:0] count_nx;
   logic             tc;
   logic             cnt_en;
   logic             cnt_clr;
   logic             accept;
   logic             phi2_nx;
   logic             rise_nx;
   logic             fall_nx;
   logic             halted_nx;
   logic             step_done_nx;
   logic             cfg_ready_nx;

`ifndef CLK_CTL_STEP_EN
   logic unused_step;
   assign unused_step = step_req;
`endif

   // Raise a zero half-period to the minimum so the counter always terminates.
   function automatic logic [DIV_W-1:0] clamp_half(input logic [DIV_W-1:0] v);
      if (v < DIV_W'(MIN_HALF)) begin
         return DIV_W'(MIN_HALF);
      end else begin
         return v;
      end
   endfunction

   phase_counter #(
      .DIV_W (DIV_W)
   ) u_phase_counter (
      .clk   (clk_in),
      .rst   (reset),
      .en    (cnt_en),
      .clr   (cnt_clr),
      .half  (half_reg),
      .count (count),
      .tc    (tc)
   );

   // Next-state, phi2/strobe, config and lookahead-ready decode.
   always_comb begin
      state_nx     = state;
      phi2_nx      = phi2;
      rise_nx      = 1'b0;
      fall_nx      = 1'b0;
      step_done_nx = 1'b0;
      accept       = cfg_valid & cfg_ready;
      if (accept) begin
         half_nx = clamp_half(cfg_half);
      end else begin
         half_nx = half_reg;
      end

      case (state)
         ST_HALT: begin
            phi2_nx = 1'b0;
            if (run_req) begin
               state_nx = ST_RUN;
            end
`ifdef CLK_CTL_STEP_EN
            else if (step_req) begin
               state_nx = ST_STEP;
            end
`endif
            else begin
               state_nx = ST_HALT;
            end
         end
         ST_RUN: begin
            if (!phi2 && !run_req) begin
               // Low phase may only be stretched, so stop right here.
               state_nx = ST_HALT;
            end else if (tc) begin
               phi2_nx = ~phi2;
               rise_nx = ~phi2;
               fall_nx = phi2;
               if (phi2 && !run_req) begin
                  state_nx = ST_HALT;
               end else begin
                  state_nx = ST_RUN;
               end
            end else begin
               state_nx = ST_RUN;
            end
         end
`ifdef CLK_CTL_STEP_EN
         ST_STEP: begin
            if (tc) begin
               phi2_nx = ~phi2;
               rise_nx = ~phi2;
               fall_nx = phi2;
               if (phi2) begin
                  step_done_nx = 1'b1;
                  state_nx     = run_req ? ST_RUN : ST_HALT;
               end else begin
                  state_nx = ST_STEP;
               end
            end else begin
               state_nx = ST_STEP;
            end
         end
`endif
         default: begin
            state_nx = ST_HALT;
            phi2_nx  = 1'b0;
         end
      endcase

      cnt_en  = (state != ST_HALT);
      cnt_clr = tc | (state_nx == ST_HALT);
      if (cnt_clr) begin
         count_nx = {DIV_W{1'b0}};
      end else if (cnt_en) begin
         count_nx = count + {{(DIV_W-1){1'b0}}, 1'b1};
      end else begin
         count_nx = count;
      end

      halted_nx    = (state_nx == ST_HALT);
      // Ready next cycle when halted or when that cycle ends a high phase.
      cfg_ready_nx = halted_nx |
                     (phi2_nx & (count_nx == (half_nx - {{(DIV_W-1){1'b0}}, 1'b1})));
   end

   // State, half-period and all registered outputs.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state     <= ST_HALT;
         half_reg  <= DIV_W'(DEF_HALF);
         phi2      <= 1'b0;
         phi2_rise <= 1'b0;
         phi2_fall <= 1'b0;
         halted    <= 1'b1;
         step_done <= 1'b0;
         cfg_ready <= 1'b1;
      end else begin
         state     <= state_nx;
         half_reg  <= half_nx;
         phi2      <= phi2_nx;
         phi2_rise <= rise_nx;
         phi2_fall <= fall_nx;
         halted    <= halted_nx;
         step_done <= step_done_nx;
         cfg_ready <= cfg_ready_nx;
      end
   end

endmodule

// File: tb/tb_clk_ctl.sv
// tb_clk_ctl: self-checking bench for clk_ctl. A phase-countdown reference
// model predicts all outputs each clk_in cycle from the controller's rules.
module tb_clk_ctl;

   localparam int DIV_W  = 4;
   localparam int M_HALT = 0;
   localparam int M_RUN  = 1;
   localparam int M_STEP = 2;
`ifdef CLK_CTL_STEP_EN
   localparam bit STEP_ON = 1'b1;
`else
   localparam bit STEP_ON = 1'b0;
`endif

   logic             clk_in    = 1'b0;
   logic             reset     = 1'b0;
   logic             run_req   = 1'b0;
   logic             step_req  = 1'b0;
   logic             cfg_valid = 1'b0;
   logic [DIV_W-1:0] cfg_half  = 4'd0;
   logic             cfg_ready;
   logic             phi2;
   logic             phi2_rise;
   logic             phi2_fall;
   logic             halted;
   logic             step_done;

   wire [5:0] obs = {phi2, phi2_rise, phi2_fall, halted, step_done, cfg_ready};

   int checks = 0;
   int errors = 0;

   // reference model: mode, phi level, cycles left in the current phase
   int m_mode;
   int m_left;
   int m_half;
   bit m_phi, m_rise, m_fall, m_done, m_acc;

   clk_ctl #(.DIV_W(DIV_W), .DEF_HALF(6)) dut (
      .clk_in    (clk_in),
      .reset     (reset),
      .run_req   (run_req),
      .step_req  (step_req),
      .cfg_valid (cfg_valid),
      .cfg_half  (cfg_half),
      .cfg_ready (cfg_ready),
      .phi2      (phi2),
      .phi2_rise (phi2_rise),
      .phi2_fall (phi2_fall),
      .halted    (halted),
      .step_done (step_done)
   );

   always #5 clk_in = ~clk_in;

   function automatic bit m_rdy();
      return (m_mode == M_HALT) || (m_phi && m_left == 1);
   endfunction

   function automatic logic [5:0] exp_vec();
      return {m_phi, m_rise, m_fall, (m_mode == M_HALT), m_done, m_rdy()};
   endfunction

   task automatic model_reset();
      m_mode = M_HALT; m_phi = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
      m_done = 1'b0; m_acc = 1'b0; m_half = 6; m_left = 0;
   endtask

   task automatic model_step();
      if (reset) begin
         model_reset();
         return;
      end
      m_acc  = cfg_valid && m_rdy();
      m_rise = 1'b0; m_fall = 1'b0; m_done = 1'b0;
      if (m_acc) m_half = (cfg_half == 4'd0) ? 1 : int'(cfg_half);
      if (m_mode == M_HALT) begin
         if (run_req) begin
            m_mode = M_RUN; m_left = m_half;
         end else if (STEP_ON && step_req) begin
            m_mode = M_STEP; m_left = m_half;
         end
      end else if (m_mode == M_RUN && !m_phi && !run_req) begin
         m_mode = M_HALT;
      end else if (m_left > 1) begin
         m_left--;
      end else begin
         m_phi  = !m_phi;
         m_rise = m_phi;
         m_fall = !m_phi;
         m_left = m_half;
         if (m_fall && m_mode == M_STEP) begin
            m_done = 1'b1;
            m_mode = run_req ? M_RUN : M_HALT;
         end else if (m_fall && m_mode == M_RUN && !run_req) begin
            m_mode = M_HALT;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      #1 reset = 1'b1;
      model_reset();
      #2;
      checks++;
      if (obs !== exp_vec()) begin
         errors++; $display("FAIL reset_async: got %b expected %b", obs, exp_vec());
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL reset_hold cyc %0d: got %b expected %b", i, obs, exp_vec());
         end
      end
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL reset_idle cyc %0d: got %b expected %b", i, obs, exp_vec());
         end
      end
   endtask

   task automatic test_run();
      int first_rise = -1;
      run_req = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (phi2_rise === 1'b1 && first_rise < 0) first_rise = i;
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL run cyc %0d: got %b expected %b", i, obs, exp_vec());
         end
      end
      checks++;
      if (first_rise != 6) begin
         errors++; $display("FAIL run_first_rise: got %0d expected 6", first_rise);
      end
   endtask

   task automatic test_halt_high();
      int guard = 0;
      run_req = 1'b1;
      while (!m_rise && guard < 40) begin
         tick(); guard++;
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL halt_high_wait: got %b expected %b", obs, exp_vec());
         end
      end
      checks++;
      if (!m_rise) begin
         errors++; $display("FAIL halt_high_timeout: got no rise expected rise");
      end
      for (int i = 0; i < 18; i++) begin
         if (i == 2) run_req = 1'b0;
         tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL halt_high cyc %0d: got %b expected %b", i, obs, exp_vec());
         end
      end
   endtask

   task automatic test_halt_low();
      int guard = 0;
      run_req = 1'b1;
      while (!m_fall && guard < 40) begin
         tick(); guard++;
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL halt_low_wait: got %b expected %b", obs, exp_vec());
         end
      end
      for (int i = 0; i < 8; i++) begin
         if (i == 2) run_req = 1'b0;
         tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL halt_low cyc %0d: got %b expected %b", i, obs, exp_vec());
         end
      end
   endtask

   task automatic test_step();
      run_req = 1'b0;
      for (int i = 0; i < 22; i++) begin
         step_req = (i == 0 || i == 5);
         tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL step cyc %0d: got %b expected %b", i, obs, exp_vec());
         end
      end
      step_req = 1'b0;
   endtask

   task automatic test_cfg();
      bit seen = 1'b0;
      run_req = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (i == 3) begin
            cfg_valid = 1'b1; cfg_half = 4'd3;
         end
         tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL cfg cyc %0d: got %b expected %b", i, obs, exp_vec());
         end
         if (m_acc) begin
            cfg_valid = 1'b0; seen = 1'b1;
         end
      end
      checks++;
      if (!seen || m_half != 3) begin
         errors++; $display("FAIL cfg_accept: got half %0d expected 3", m_half);
      end
   endtask

   task automatic test_cfg_zero();
      run_req = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (m_mode == M_HALT) cfg_valid = 1'b1;
         cfg_half = 4'd0;
         if (i == 12) run_req = 1'b1;
         if (i == 24) run_req = 1'b0;
         tick();
         if (m_acc) cfg_valid = 1'b0;
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL cfg_zero cyc %0d: got %b expected %b", i, obs, exp_vec());
         end
      end
      cfg_valid = 1'b0;
   endtask

   task automatic test_async_reset();
      int guard = 0;
      cfg_valid = 1'b1; cfg_half = 4'd3;
      tick();
      cfg_valid = 1'b0;
      run_req = 1'b1;
      while (!m_rise && guard < 20) begin
         tick(); guard++;
      end
      tick();
      #2 reset = 1'b1;
      model_reset();
      #1;
      checks++;
      if ({phi2, halted} !== 2'b01 || obs !== exp_vec()) begin
         errors++; $display("FAIL async_reset: got %b expected %b", obs, exp_vec());
      end
      tick(); tick();
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL after_reset cyc %0d: got %b expected %b", i, obs, exp_vec());
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 19) == 0) run_req = ~run_req;
         step_req = ($urandom_range(0, 15) == 0);
         if (!cfg_valid && $urandom_range(0, 30) == 0) begin
            cfg_valid = 1'b1;
            cfg_half  = 4'($urandom_range(0, 7));
         end
         tick();
         if (m_acc) cfg_valid = 1'b0;
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL random cyc %0d: got %b expected %b", i, obs, exp_vec());
         end
         checks++;
         if ((phi2_rise & phi2_fall) !== 1'b0) begin
            errors++; $display("FAIL strobe_excl cyc %0d: got rise %b fall %b expected not both", i, phi2_rise, phi2_fall);
         end
      end
      step_req = 1'b0; cfg_valid = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_run();
      test_halt_high();
      test_step();
      test_halt_low();
      test_cfg();
      test_cfg_zero();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
